// File: rtl/safety_pkg.sv
// Shared types and constants for the safety status transmitter.
// SAFETY_TX_PARITY_EN adds an even-parity bit after D7.
package safety_pkg;

    localparam int unsigned STATUS_W  = 5;
    localparam int unsigned SEQ_W     = 3;
    localparam int unsigned DATA_BITS = 8;

    localparam int unsigned BIT_LEFT  = 0;
    localparam int unsigned BIT_RIGHT = 1;
    localparam int unsigned BIT_HORN  = 2;
    localparam int unsigned BIT_HEAD  = 3;
    localparam int unsigned BIT_BRAKE = 4;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    typedef struct packed {
        logic brake;
        logic head_light;
        logic horn;
        logic right_blink;
        logic left_blink;
    } status_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef SAFETY_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } tx_state_e;

`ifdef SAFETY_TX_PARITY_EN
    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction
`endif

endpackage

// File: rtl/safety_uart_tx_core.sv
// UART byte serialiser: start, 8 data bits LSB first, optional parity, stop.
// SAFETY_TX_PARITY_EN inserts an even-parity bit between D7 and stop.
module safety_uart_tx_core
    import safety_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] data,
    output logic                 txd,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CNT_W     = $clog2(BAUD_DIV);
    localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS);

    tx_state_e              state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]       baud_cnt_q, baud_cnt_d;
    logic                   txd_q, txd_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   bit_tick;
`ifdef SAFETY_TX_PARITY_EN
    logic                   par_q, par_d;
`endif

    assign bit_tick = (baud_cnt_q == CNT_W'(BAUD_DIV - 1));

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        done_d     = 1'b0;
`ifdef SAFETY_TX_PARITY_EN
        par_d      = par_q;
`endif
        if (state_q != S_IDLE && state_q != S_LOAD) begin
            baud_cnt_d = bit_tick ? '0 : baud_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d = S_LOAD;
                    shift_d = data;
`ifdef SAFETY_TX_PARITY_EN
                    par_d   = even_parity(data);
`endif
                end
            end
            S_LOAD: begin
                state_d    = S_START;
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
            end
            S_START: begin
                if (bit_tick) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
`ifdef SAFETY_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef SAFETY_TX_PARITY_EN
            S_PARITY: begin
                if (bit_tick) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_tick) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level is derived from the next state so txd comes straight off a flop.
        case (state_d)
            S_START:  txd_d = START_LVL;
            S_DATA:   txd_d = shift_d[0];
`ifdef SAFETY_TX_PARITY_EN
            S_PARITY: txd_d = par_d;
`endif
            default:  txd_d = STOP_LVL;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            txd_q      <= STOP_LVL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SAFETY_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef SAFETY_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/safety_status_tx.sv
// Dashboard status link: sends {seq, status} on change, after reset, and on heartbeat.
// SAFETY_TX_PARITY_EN (handled in the core) adds an even-parity bit per frame.
module safety_status_tx
    import safety_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned HEARTBEAT_MS = 100
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    input  logic leftBlinkerIn,
    input  logic rightBlinkerIn,
    input  logic headLightIn,
    input  logic hornIn,
    input  logic brakeIn,
    output logic txd,
    output logic busy,
    output logic frame_sent
);

    localparam int unsigned BAUD_DIV  = CLK_HZ / BAUD;
    localparam int unsigned HB_CYCLES = CLK_HZ / 1000 * HEARTBEAT_MS;
    localparam int unsigned HB_W      = $clog2(HB_CYCLES);

    logic [STATUS_W-1:0]  s_raw;
    status_t              sync1_q, sync1_d;
    status_t              sync2_q, sync2_d;
    status_t              last_sent_q, last_sent_d;
    logic                 force_q, force_d;
    logic [HB_W-1:0]      hb_q, hb_d;
    logic [SEQ_W-1:0]     seq_q, seq_d;
    logic [SEQ_W-1:0]     seq_cur;
    logic                 hb_expired;
    logic                 trigger;
    logic [DATA_BITS-1:0] payload;
    logic                 core_busy;
    logic                 core_done;

    always_comb begin
        s_raw            = '0;
        s_raw[BIT_LEFT]  = leftBlinkerIn;
        s_raw[BIT_RIGHT] = rightBlinkerIn;
        s_raw[BIT_HORN]  = hornIn;
        s_raw[BIT_HEAD]  = headLightIn;
        s_raw[BIT_BRAKE] = brakeIn;
    end

    // The core's done pulse lands on the first idle cycle, so a back-to-back
    // frame triggered in that cycle must already see the incremented seq.
    always_comb begin
        sync1_d     = status_t'(s_raw);
        sync2_d     = sync1_q;
        seq_cur     = core_done ? seq_q + 1'b1 : seq_q;
        seq_d       = seq_cur;
        hb_expired  = (hb_q == HB_W'(HB_CYCLES - 1));
        trigger     = !core_busy && (force_q || (sync2_q != last_sent_q) || hb_expired);
        last_sent_d = last_sent_q;
        force_d     = force_q;
        hb_d        = hb_q;
        if (trigger) begin
            last_sent_d = sync2_q;
            force_d     = 1'b0;
            hb_d        = '0;
        end else if (!core_busy && !hb_expired) begin
            hb_d = hb_q + 1'b1;
        end
        payload = {seq_cur, sync2_q};
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            last_sent_q <= '0;
            force_q     <= 1'b1;
            hb_q        <= '0;
            seq_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            last_sent_q <= last_sent_d;
            force_q     <= force_d;
            hb_q        <= hb_d;
            seq_q       <= seq_d;
        end
    end

    safety_uart_tx_core #(
        .BAUD_DIV (BAUD_DIV)
    ) u_core (
        .clk   (CLOCK_50),
        .rst_n (reset_n),
        .load  (trigger),
        .data  (payload),
        .txd   (txd),
        .busy  (core_busy),
        .done  (core_done)
    );

    assign busy       = core_busy;
    assign frame_sent = core_done;

endmodule

// File: tb/tb_safety_status_tx.sv
// Scoreboard bench for safety_status_tx: a line decoder checks every frame
// against payloads queued by the stimulus, plus timing of starts and heartbeats.
module tb_safety_status_tx;

    localparam int unsigned CLK_HZ = 1000000;
    localparam int unsigned BAUD   = 100000;
    localparam int unsigned HB_MS  = 2;
    localparam int DIV = CLK_HZ / BAUD;
    localparam int HB  = CLK_HZ / 1000 * HB_MS;
`ifdef SAFETY_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic left_in = 1'b0, right_in = 1'b0, head_in = 1'b0, horn_in = 1'b0, brake_in = 1'b0;
    logic txd, busy, frame_sent;

    int n_total = 0;
    int n_bad = 0;
    int cyc = 0;
    int frames_seen = 0;
    bit mon_en = 1'b0;
    logic [7:0] exp_q[$];
    int start_cyc[$];
    int done_cyc[$];

    safety_status_tx #(
        .CLK_HZ       (CLK_HZ),
        .BAUD         (BAUD),
        .HEARTBEAT_MS (HB_MS)
    ) dut (
        .CLOCK_50       (clk),
        .reset_n        (rst_n),
        .leftBlinkerIn  (left_in),
        .rightBlinkerIn (right_in),
        .headLightIn    (head_in),
        .hornIn         (horn_in),
        .brakeIn        (brake_in),
        .txd            (txd),
        .busy           (busy),
        .frame_sent     (frame_sent)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t;
        t = 0;
        while (frames_seen < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("frame_count", frames_seen, n);
    endtask

    task automatic wait_busy(input int budget);
        int t;
        t = 0;
        while (busy !== 1'b1 && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("busy_rise", busy, 1);
    endtask

    task automatic wait_txd_low(input int budget);
        int t;
        t = 0;
        while (txd !== 1'b0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("txd_fall", txd, 0);
    endtask

    // Line decoder: samples each bit at its midpoint and pops the expected payload.
    initial begin : monitor
        logic [7:0] rx;
        logic [7:0] e;
        int k;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && txd === 1'b0) begin
                k = cyc;
                start_cyc.push_back(k);
                repeat (DIV / 2) @(negedge clk);
                chk("start_bit", txd, 0);
                chk("busy_mid", busy, 1);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    rx[i] = txd;
                end
`ifdef SAFETY_TX_PARITY_EN
                repeat (DIV) @(negedge clk);
                chk("parity_bit", txd, ^rx);
`endif
                repeat (DIV) @(negedge clk);
                chk("stop_bit", txd, 1);
                chk("sent_early", frame_sent, 0);
                repeat (DIV - DIV / 2) @(negedge clk);
                chk("frame_sent", frame_sent, 1);
                chk("busy_end", busy, 0);
                chk("frame_len", cyc - k, NB * DIV);
                done_cyc.push_back(cyc);
                chk("exp_avail", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = ~rx;
                chk("payload", rx, e);
                frames_seen++;
                @(negedge clk);
                chk("sent_pulse", frame_sent, 0);
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c0;
        int k;
        int target;

        // Reset state, then the forced post-reset frame with seq 0.
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_sent", frame_sent, 0);
        exp_q.push_back(8'h00);
        mon_en = 1'b1;
        rst_n = 1'b1;
        c0 = cyc;
        wait_frames(1, 300);
        chk("rst_latency", (start_cyc[0] - c0 >= 1) && (start_cyc[0] - c0 <= 4), 1);

        repeat (1500) @(negedge clk);
        chk("quiet_idle", frames_seen, 1);

        // Left blinker: 2 sync + trigger + LOAD; brake glitch mid-frame is dropped.
        left_in = 1'b1;
        c0 = cyc;
        exp_q.push_back(8'h21);
        wait_busy(20);
        repeat (20) @(negedge clk);
        brake_in = 1'b1;
        repeat (30) @(negedge clk);
        brake_in = 1'b0;
        wait_frames(2, 200);
        chk("left_latency", start_cyc[1] - c0, 4);
        repeat (300) @(negedge clk);
        chk("glitch_dropped", frames_seen, 2);

        // Brake held during a frame re-triggers right after the stop bit.
        right_in = 1'b1;
        exp_q.push_back(8'h43);
        wait_busy(20);
        repeat (20) @(negedge clk);
        brake_in = 1'b1;
        exp_q.push_back(8'h73);
        wait_frames(4, 400);
        chk("b2b_gap", start_cyc[3] - done_cyc[2], 2);

        // Headlight change reaches the status vector on the heartbeat expiry cycle.
        target = done_cyc[3] + HB - 3;
        k = 0;
        while (cyc < target && k < 3 * HB) begin
            @(negedge clk);
            k++;
        end
        head_in = 1'b1;
        exp_q.push_back(8'h9B);
        exp_q.push_back(8'hBB);
        wait_frames(6, 2 * HB + 400);
        chk("hb_coincide", start_cyc[4] - done_cyc[3], HB + 1);
        chk("no_duplicate", start_cyc[5] - done_cyc[4], HB + 1);

        // Steady inputs: heartbeat frames, seq wraps 7 -> 0.
        exp_q.push_back(8'hDB);
        exp_q.push_back(8'hFB);
        exp_q.push_back(8'h1B);
        wait_frames(9, 3 * (HB + 200));
        for (int i = 6; i < 9; i++) chk("hb_interval", start_cyc[i] - done_cyc[i-1], HB + 1);

        horn_in = 1'b1;
        exp_q.push_back(8'h3F);
        wait_frames(10, 200);
        left_in = 1'b0;
        right_in = 1'b0;
        head_in = 1'b0;
        horn_in = 1'b0;
        brake_in = 1'b0;
        exp_q.push_back(8'h40);
        wait_frames(11, 200);

        // Reset in the middle of data bit 3 of an unmonitored frame (payload 0x61).
        mon_en = 1'b0;
        repeat (5) @(negedge clk);
        left_in = 1'b1;
        wait_txd_low(20);
        repeat (4 * DIV + DIV / 2) @(negedge clk);
        chk("bit3_before_rst", txd, 0);
        chk("busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_txd", txd, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_sent", frame_sent, 0);
        left_in = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.push_back(8'h00);
        mon_en = 1'b1;
        rst_n = 1'b1;
        wait_frames(12, 300);

        repeat (50) @(negedge clk);
        chk("exp_drained", exp_q.size(), 0);
        chk("final_frames", frames_seen, 12);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
